eth_mac_tx_arb_n: RTL and testbench

- N-channel frame-granular transmit arbiter in the MAC transmit clock domain.
- Sits between N per-source async TX FIFOs (8-bit master side) and the single 8-bit transmit AXI-stream input of the 1G MAC.
- Selects whole frames by round-robin or fixed priority and forwards them byte by byte.
- Adds stall detection: a source that starves mid-frame gets its frame aborted with tuser=1, so the MAC never underflows silently.
- Emits per-channel frame status pulses.

---
 rtl/eth_mac_tx_arb_n_pkg.sv | 13 +
 rtl/eth_tx_rr_arbiter.sv | 39 +++
 rtl/eth_mac_tx_arb_n.sv | 197 +++++++++++++++++++
 tb/tb_eth_mac_tx_arb_n.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mac_tx_arb_n_pkg.sv
// Shared definitions for the frame-granular MAC transmit arbiter.
// State encoding is kept as plain constants for compatibility with older tooling.
package eth_mac_tx_arb_n_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StXfer  = 2'd1;
  localparam logic [1:0] StAbort = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam string ArbModeRr       = "RR";
  localparam string ArbModePriority = "PRIORITY";

endpackage

// File: rtl/eth_tx_rr_arbiter.sv
// Combinational frame arbiter: round-robin after a pointer, or fixed lowest-index priority.
// Produces both a one-hot grant and its encoded index.
module eth_tx_rr_arbiter #(
  parameter int unsigned Channels = 4,
  parameter int unsigned IdxW     = $clog2(Channels),
  parameter bit          PrioMode = 1'b0
) (
  input  logic [Channels-1:0] req_i,
  input  logic [IdxW-1:0]     ptr_i,
  output logic [Channels-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // First pass: indices strictly after the pointer (or all indices in priority mode).
    for (int i = 0; i < int'(Channels); i++) begin
      if (!valid_o && req_i[i] && (PrioMode || i > int'(ptr_i))) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    // Second pass wraps around to the pointer itself.
    if (!PrioMode) begin
      for (int i = 0; i < int'(Channels); i++) begin
        if (!valid_o && req_i[i] && i <= int'(ptr_i)) begin
          valid_o  = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IdxW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/eth_mac_tx_arb_n.sv
// N-channel frame-granular transmit arbiter feeding the 8-bit MAC AXI-stream input.
// Whole frames are forwarded through one output register; starved sources get aborted.
module eth_mac_tx_arb_n
  import eth_mac_tx_arb_n_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter string       ARB_MODE      = ArbModeRr,
  parameter int unsigned STALL_TIMEOUT = 16,
  parameter int unsigned CHAN_WIDTH    = $clog2(CHANNELS)
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic [CHANNELS*8-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]   s_axis_tvalid,
  output logic [CHANNELS-1:0]   s_axis_tready,
  input  logic [CHANNELS-1:0]   s_axis_tlast,
  input  logic [CHANNELS-1:0]   s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic [CHANNELS-1:0]   chan_enable,
  output logic [CHAN_WIDTH-1:0] active_chan,
  output logic                  busy,
  output logic [CHANNELS-1:0]   status_good_frame,
  output logic [CHANNELS-1:0]   status_bad_frame,
  output logic [CHANNELS-1:0]   status_stall_abort
);

  localparam bit              PrioMode  = (ARB_MODE == ArbModePriority);
  localparam bit              StallEn   = (STALL_TIMEOUT != 0);
  localparam int unsigned     CntW      = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] StallLast = StallEn ? CntW'(STALL_TIMEOUT - 1) : '0;

  logic [1:0]            state_q, state_d;
  logic [CHAN_WIDTH-1:0] grant_q, grant_d;
  logic [CHANNELS-1:0]   grant_oh_q, grant_oh_d;
  logic [CHAN_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]       stall_cnt_q, stall_cnt_d;
  logic [7:0]            m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;
  logic [CHANNELS-1:0]   good_q, good_d;
  logic [CHANNELS-1:0]   bad_q, bad_d;
  logic [CHANNELS-1:0]   abort_q, abort_d;

  logic [CHANNELS-1:0]   arb_oh;
  logic [CHAN_WIDTH-1:0] arb_idx;
  logic                  arb_valid;

  logic       out_free;
  logic       src_valid, src_last, src_user;
  logic [7:0] src_data;

  eth_tx_rr_arbiter #(
    .Channels (CHANNELS),
    .IdxW     (CHAN_WIDTH),
    .PrioMode (PrioMode)
  ) u_arbiter (
    .req_i   (chan_enable & s_axis_tvalid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_oh),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign out_free  = !m_valid_q || m_axis_tready;
  assign src_valid = s_axis_tvalid[grant_q];
  assign src_last  = s_axis_tlast[grant_q];
  assign src_user  = s_axis_tuser[grant_q];
  assign src_data  = s_axis_tdata[{grant_q, 3'b000} +: 8];

  always_comb begin
    s_axis_tready = '0;
    if (state_q == StXfer) begin
      s_axis_tready = grant_oh_q & {CHANNELS{out_free}};
    end else if (state_q == StDrain) begin
      s_axis_tready = grant_oh_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    stall_cnt_d = stall_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    good_d      = '0;
    bad_d       = '0;
    abort_d     = '0;

    if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        stall_cnt_d = '0;
        if (arb_valid) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          state_d    = StXfer;
        end
      end
      StXfer: begin
        if (out_free) begin
          if (src_valid) begin
            m_data_d    = src_data;
            m_valid_d   = 1'b1;
            m_last_d    = src_last;
            m_user_d    = src_user;
            stall_cnt_d = '0;
            if (src_last) begin
              state_d  = StIdle;
              rr_ptr_d = grant_q;
              if (src_user) begin
                bad_d = grant_oh_q;
              end else begin
                good_d = grant_oh_q;
              end
            end
          end else if (StallEn && stall_cnt_q == StallLast) begin
            // Terminate the frame at the MAC with an explicit bad last beat.
            m_data_d    = 8'h00;
            m_valid_d   = 1'b1;
            m_last_d    = 1'b1;
            m_user_d    = 1'b1;
            stall_cnt_d = '0;
            state_d     = StAbort;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
      end
      StAbort: begin
        if (m_axis_tready) begin
          abort_d  = grant_oh_q;
          rr_ptr_d = grant_q;
          state_d  = StDrain;
        end
      end
      StDrain: begin
        if (src_valid && src_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= CHAN_WIDTH'(CHANNELS - 1);
      stall_cnt_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      good_q      <= '0;
      bad_q       <= '0;
      abort_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      abort_q     <= abort_d;
    end
  end

  assign m_axis_tdata       = m_data_q;
  assign m_axis_tvalid      = m_valid_q;
  assign m_axis_tlast       = m_last_q;
  assign m_axis_tuser       = m_user_q;
  assign active_chan        = grant_q;
  assign busy               = (state_q != StIdle);
  assign status_good_frame  = good_q;
  assign status_bad_frame   = bad_q;
  assign status_stall_abort = abort_q;

endmodule

// File: tb/tb_eth_mac_tx_arb_n.sv
// Directed bench for eth_mac_tx_arb_n: a round-robin and a priority instance share stimulus;
// queue-based sources and an output log are advanced one clock at a time by step().
module tb_eth_mac_tx_arb_n;

  localparam int CH = 4;

  logic          tx_clk = 1'b0;
  logic          tx_rst = 1'b0;
  logic [CH*8-1:0] s_tdata;
  logic [CH-1:0] s_tvalid, s_tlast, s_tuser, chan_enable;
  logic          m_tready;
  logic          sel_p;

  logic [CH-1:0] r_s_tready, p_s_tready;
  logic [7:0]    r_m_tdata, p_m_tdata;
  logic          r_m_tvalid, p_m_tvalid, r_m_tlast, p_m_tlast, r_m_tuser, p_m_tuser;
  logic [1:0]    r_active, p_active;
  logic          r_busy, p_busy;
  logic [CH-1:0] r_good, p_good, r_bad, p_bad, r_abrt, p_abrt;

  logic [CH-1:0] s_tready, good, bad, abrt;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tlast, m_tuser, busy;
  logic [1:0]    active;

  assign s_tready = sel_p ? p_s_tready : r_s_tready;
  assign m_tdata  = sel_p ? p_m_tdata  : r_m_tdata;
  assign m_tvalid = sel_p ? p_m_tvalid : r_m_tvalid;
  assign m_tlast  = sel_p ? p_m_tlast  : r_m_tlast;
  assign m_tuser  = sel_p ? p_m_tuser  : r_m_tuser;
  assign active   = sel_p ? p_active   : r_active;
  assign busy     = sel_p ? p_busy     : r_busy;
  assign good     = sel_p ? p_good     : r_good;
  assign bad      = sel_p ? p_bad      : r_bad;
  assign abrt     = sel_p ? p_abrt     : r_abrt;

  eth_mac_tx_arb_n #(
    .CHANNELS(CH), .ARB_MODE("RR"), .STALL_TIMEOUT(16)
  ) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(r_s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(r_m_tdata), .m_axis_tvalid(r_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(r_m_tlast), .m_axis_tuser(r_m_tuser),
    .chan_enable(chan_enable), .active_chan(r_active), .busy(r_busy),
    .status_good_frame(r_good), .status_bad_frame(r_bad), .status_stall_abort(r_abrt)
  );

  eth_mac_tx_arb_n #(
    .CHANNELS(CH), .ARB_MODE("PRIORITY"), .STALL_TIMEOUT(16)
  ) dut_p (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(p_s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(p_m_tdata), .m_axis_tvalid(p_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(p_m_tlast), .m_axis_tuser(p_m_tuser),
    .chan_enable(chan_enable), .active_chan(p_active), .busy(p_busy),
    .status_good_frame(p_good), .status_bad_frame(p_bad), .status_stall_abort(p_abrt)
  );

  always #5 tx_clk = ~tx_clk;

  // Source entry: {idle_marker, tuser, tlast, tdata}; log entry: {tuser, tlast, tdata}.
  logic [10:0] srcq [CH][$];
  logic [9:0]  out_log[$];
  logic [9:0]  exp_log[$];
  logic [5:0]  ev_log[$];
  logic [5:0]  ev_exp[$];
  int          gap_log[$];
  logic [CH-1:0] hs_pend, idle_pend;
  logic [3:0]  rdy_pat;
  int          cyc, gap_cnt, n_cmp, n_bad;
  bit          seen_last;

  task automatic step();
    @(negedge tx_clk);
    for (int i = 0; i < CH; i++)
      if ((hs_pend[i] || idle_pend[i]) && srcq[i].size() > 0) void'(srcq[i].pop_front());
    hs_pend   = '0;
    idle_pend = '0;
    m_tready  = rdy_pat[cyc % 4];
    for (int i = 0; i < CH; i++) begin
      if (srcq[i].size() > 0 && !srcq[i][0][10]) begin
        s_tvalid[i]         = 1'b1;
        s_tuser[i]          = srcq[i][0][9];
        s_tlast[i]          = srcq[i][0][8];
        s_tdata[8*i +: 8]   = srcq[i][0][7:0];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tuser[i]          = 1'b0;
        s_tlast[i]          = 1'b0;
        s_tdata[8*i +: 8]   = 8'h00;
        idle_pend[i]        = (srcq[i].size() > 0);
      end
    end
    #1;
    hs_pend = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      if (seen_last) gap_log.push_back(gap_cnt);
      gap_cnt   = 0;
      seen_last = m_tlast;
      out_log.push_back({m_tuser, m_tlast, m_tdata});
    end else if (!m_tvalid) begin
      gap_cnt++;
    end
    for (int i = 0; i < CH; i++) begin
      if (good[i]) ev_log.push_back({2'd0, 4'(i)});
      if (bad[i])  ev_log.push_back({2'd1, 4'(i)});
      if (abrt[i]) ev_log.push_back({2'd2, 4'(i)});
    end
    cyc++;
  endtask

  task automatic add_beats(input int ch, input int n, input int base, input bit last,
                           input bit bad_last, input bit keep);
    for (int k = 0; k < n; k++) begin
      logic l, u;
      l = last && (k == n - 1);
      u = bad_last && (k == n - 1);
      srcq[ch].push_back({1'b0, u, l, 8'(base + k)});
      if (keep) exp_log.push_back({u, l, 8'(base + k)});
    end
  endtask

  task automatic add_idle(input int ch, input int n);
    for (int k = 0; k < n; k++) srcq[ch].push_back(11'h400);
  endtask

  task automatic clear_logs();
    out_log.delete(); exp_log.delete(); ev_log.delete(); ev_exp.delete(); gap_log.delete();
    gap_cnt   = 0;
    seen_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge tx_clk);
    tx_rst = 1'b1;
    for (int i = 0; i < CH; i++) srcq[i].delete();
    hs_pend = '0; idle_pend = '0;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
    @(negedge tx_clk);
    tx_rst = 1'b0;
  endtask

  task automatic check_logs(input string tag);
    n_cmp++;
    if (out_log.size() != exp_log.size()) begin
      $display("FAIL %s_nbytes: got %0d beats, want %0d", tag, out_log.size(), exp_log.size());
      n_bad++;
    end
    for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
      n_cmp++;
      if (out_log[k] !== exp_log[k]) begin
        $display("FAIL %s_beat%0d: got %h, want %h", tag, k, out_log[k], exp_log[k]);
        n_bad++;
      end
    end
    n_cmp++;
    if (ev_log.size() != ev_exp.size()) begin
      $display("FAIL %s_nevents: got %0d status pulses, want %0d", tag, ev_log.size(),
               ev_exp.size());
      n_bad++;
    end
    for (int k = 0; k < ev_exp.size() && k < ev_log.size(); k++) begin
      n_cmp++;
      if (ev_log[k] !== ev_exp[k]) begin
        $display("FAIL %s_event%0d: got %h, want %h", tag, k, ev_log[k], ev_exp[k]);
        n_bad++;
      end
    end
  endtask

  task automatic test_reset();
    #1 tx_rst = 1'b1;
    #1;
    n_cmp++;
    if ({r_m_tvalid, r_m_tlast, r_m_tuser, r_m_tdata} !== 11'h000) begin
      $display("FAIL reset_mout: got v=%b l=%b u=%b d=%h, want 0", r_m_tvalid, r_m_tlast,
               r_m_tuser, r_m_tdata);
      n_bad++;
    end
    n_cmp++;
    if ({r_busy, r_active, r_s_tready, r_good, r_bad, r_abrt} !== 19'h0) begin
      $display("FAIL reset_ctrl: got busy=%b act=%0d rdy=%b g=%b b=%b a=%b, want 0", r_busy,
               r_active, r_s_tready, r_good, r_bad, r_abrt);
      n_bad++;
    end
    @(negedge tx_clk);
    tx_rst = 1'b0;
  endtask

  task automatic test_rr_fairness();
    do_reset(); clear_logs();
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < CH; c++) begin
        add_beats(c, 4, c * 16 + f * 8, 1'b1, 1'b0, 1'b1);
        ev_exp.push_back({2'd0, 4'(c)});
      end
    for (int t = 0; t < 300 && ev_log.size() < 8; t++) step();
    step(); step();
    check_logs("rr");
    n_cmp++;
    if (gap_log.size() != 7) begin
      $display("FAIL rr_ngaps: got %0d gaps, want 7", gap_log.size());
      n_bad++;
    end
    foreach (gap_log[k]) begin
      n_cmp++;
      if (gap_log[k] != 1) begin
        $display("FAIL rr_gap%0d: got %0d idle cycles, want 1", k, gap_log[k]);
        n_bad++;
      end
    end
  endtask

  task automatic test_stall_abort();
    do_reset(); clear_logs();
    add_beats(2, 10, 8'h20, 1'b0, 1'b0, 1'b1);
    add_idle(2, 16);
    add_beats(2, 5, 8'h60, 1'b1, 1'b0, 1'b0);
    exp_log.push_back(10'h300);
    ev_exp.push_back({2'd2, 4'd2});
    for (int t = 0; t < 200 && (srcq[2].size() > 0 || busy); t++) step();
    step(); step();
    n_cmp++;
    if (srcq[2].size() != 0 || busy !== 1'b0) begin
      $display("FAIL stall_drain: got %0d beats left busy=%b, want 0 and 0", srcq[2].size(),
               busy);
      n_bad++;
    end
    check_logs("stall");
  endtask

  task automatic test_stall_below_limit();
    do_reset(); clear_logs();
    add_beats(0, 3, 8'h40, 1'b0, 1'b0, 1'b1);
    add_idle(0, 15);
    add_beats(0, 2, 8'h43, 1'b1, 1'b0, 1'b1);
    ev_exp.push_back({2'd0, 4'd0});
    for (int t = 0; t < 200 && ev_log.size() < 1; t++) step();
    step(); step();
    check_logs("gap15");
  endtask

  task automatic test_backpressure();
    do_reset(); clear_logs();
    rdy_pat = 4'b1001;
    add_beats(0, 64, 8'h80, 1'b1, 1'b0, 1'b1);
    ev_exp.push_back({2'd0, 4'd0});
    for (int t = 0; t < 600 && ev_log.size() < 1; t++) step();
    for (int t = 0; t < 6; t++) step();
    rdy_pat = 4'hF;
    check_logs("bp");
  endtask

  task automatic test_bad_and_enable();
    do_reset(); clear_logs();
    add_beats(1, 3, 8'hB0, 1'b1, 1'b1, 1'b1);
    ev_exp.push_back({2'd1, 4'd1});
    for (int t = 0; t < 100 && ev_log.size() < 1; t++) step();
    step(); step();
    check_logs("bad");
    clear_logs();
    chan_enable = 4'b1101;
    add_beats(1, 3, 8'hC0, 1'b1, 1'b0, 1'b0);
    add_beats(2, 3, 8'hD0, 1'b1, 1'b0, 1'b1);
    ev_exp.push_back({2'd0, 4'd2});
    for (int t = 0; t < 40; t++) step();
    check_logs("gate");
    n_cmp++;
    if (srcq[1].size() != 3) begin
      $display("FAIL gate_ch1: got %0d beats left on ch1, want 3", srcq[1].size());
      n_bad++;
    end
    chan_enable = 4'hF;
  endtask

  task automatic test_reset_mid_frame();
    do_reset(); clear_logs();
    add_beats(2, 2, 8'h10, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 100 && ev_log.size() < 1; t++) step();
    add_beats(1, 10, 8'h50, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 100 && out_log.size() < 7; t++) step();
    #2 tx_rst = 1'b1;
    #1;
    n_cmp++;
    if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== 11'h000) begin
      $display("FAIL rstmid_mout: got v=%b l=%b u=%b d=%h, want 0", m_tvalid, m_tlast,
               m_tuser, m_tdata);
      n_bad++;
    end
    n_cmp++;
    if ({busy, active, s_tready, good, bad, abrt} !== 19'h0) begin
      $display("FAIL rstmid_ctrl: got busy=%b act=%0d rdy=%b, want 0", busy, active, s_tready);
      n_bad++;
    end
    for (int i = 0; i < CH; i++) srcq[i].delete();
    hs_pend = '0; idle_pend = '0; s_tvalid = '0;
    @(negedge tx_clk);
    tx_rst = 1'b0;
    clear_logs();
    add_beats(0, 2, 8'h70, 1'b1, 1'b0, 1'b1);
    add_beats(3, 2, 8'h90, 1'b1, 1'b0, 1'b1);
    ev_exp.push_back({2'd0, 4'd0});
    ev_exp.push_back({2'd0, 4'd3});
    for (int t = 0; t < 100 && ev_log.size() < 2; t++) step();
    step(); step();
    check_logs("rstmid");
  endtask

  task automatic test_priority();
    sel_p = 1'b1;
    do_reset(); clear_logs();
    for (int f = 0; f < 3; f++) begin
      add_beats(1, 2, 8'hA0 + f * 2, 1'b1, 1'b0, 1'b1);
      ev_exp.push_back({2'd0, 4'd1});
    end
    for (int f = 0; f < 2; f++) begin
      add_beats(3, 2, 8'hE0 + f * 2, 1'b1, 1'b0, 1'b1);
      ev_exp.push_back({2'd0, 4'd3});
    end
    for (int t = 0; t < 200 && ev_log.size() < 5; t++) step();
    step(); step();
    check_logs("prio");
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    sel_p = 1'b0; rdy_pat = 4'hF; m_tready = 1'b1; chan_enable = 4'hF;
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0;
    hs_pend = '0; idle_pend = '0;
    clear_logs();
    test_reset();
    test_rr_fairness();
    test_stall_abort();
    test_stall_below_limit();
    test_backpressure();
    test_bad_and_enable();
    test_reset_mid_frame();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
